// File: rtl/core_pkg.sv
// Shared IF-stage definitions: PC width, reset vector, instruction size and redirect source encoding.
package core_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_VECTOR = '0;

    typedef logic [XLEN-1:0] pc_t;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_MRET   = 2'd2,
        RD_TRAP   = 2'd3
    } redirect_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request/response bus between the PC generator (master) and instruction memory (slave).
interface pc_gen_if #(
    parameter int unsigned XLEN = core_pkg::XLEN
);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_pc;
    logic            resp_valid;
    logic            resp_drop;

    modport master (
        output req_valid,
        output req_pc,
        output resp_drop,
        input  req_ready,
        input  resp_valid
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  resp_drop,
        output req_ready,
        output resp_valid
    );

endinterface

// File: rtl/pc_inflight_tracker.sv
// Counts in-flight fetch requests and how many of them were issued before the latest redirect.
module pc_inflight_tracker #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    input  logic resp_valid,
    input  logic redirect,
    output logic can_issue,
    output logic resp_drop
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] kill_cnt;
    logic [CNT_W-1:0] kill_nxt;
    logic             dec;

    assign dec       = resp_valid && (outstanding != '0);
    assign resp_drop = resp_valid && (kill_cnt != '0);
    assign can_issue = (outstanding < CNT_W'(MAX_OUTSTANDING));

    // A redirect marks everything still in flight after this cycle as stale, replacing any older count.
    always_comb begin
        outstanding_nxt = outstanding + CNT_W'(fire) - CNT_W'(dec);
        kill_nxt        = kill_cnt;
        if (redirect) begin
            kill_nxt = outstanding_nxt;
        end else if (resp_drop) begin
            kill_nxt = kill_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            kill_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            kill_cnt    <= kill_nxt;
        end
    end

    a_no_orphan_resp: assert property (
        @(posedge clk) disable iff (rst) !(resp_valid && (outstanding == '0))
    ) else $error("resp_valid with no outstanding fetch request");

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: redirect selection (trap > mret > branch), fetch issue and stale-response marking.
module pc_gen #(
    parameter int unsigned     XLEN            = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR    = XLEN'(core_pkg::RESET_VECTOR),
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_take,
    input  logic [XLEN-1:0] mret_pc,
    input  logic            branch_take,
    input  logic [XLEN-1:0] branch_pc,
    pc_gen_if.master        bus,
    output logic            misalign,
    output logic [XLEN-1:0] pc_out
);

    import core_pkg::*;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    redirect_src_e   src;
    logic            redirect;
    logic            rst_q;
    logic            can_issue;
    logic            fire;

    // Redirect source priority: trap over mret over branch.
    always_comb begin
        src    = RD_NONE;
        target = branch_pc;
        if (trap_take) begin
            src    = RD_TRAP;
            target = trap_pc;
        end else if (mret_take) begin
            src    = RD_MRET;
            target = mret_pc;
        end else if (branch_take) begin
            src    = RD_BRANCH;
            target = branch_pc;
        end
    end

    assign redirect = (src != RD_NONE);

    // Holds off issue for one cycle after reset release.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign bus.req_valid = !rst_q && !stall && can_issue;
    assign fire          = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            misalign <= 1'b0;
        end else begin
            misalign <= redirect && (target[1:0] != 2'b00);
            if (redirect) begin
                pc <= {target[XLEN-1:2], 2'b00};
            end else if (fire) begin
                pc <= pc + XLEN'(INSTR_BYTES);
            end
        end
    end

    assign bus.req_pc = pc;
    assign pc_out     = pc;

    pc_inflight_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .fire       (fire),
        .resp_valid (bus.resp_valid),
        .redirect   (redirect),
        .can_issue  (can_issue),
        .resp_drop  (bus.resp_drop)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/issue, streaming, stall+redirect, stale drops, priority, wrap and mid-stream reset.
module tb_pc_gen;

    import core_pkg::*;

    localparam int unsigned NV = 24;

    typedef struct {
        logic        stall;
        logic        tt;
        logic [31:0] tpc;
        logic        mt;
        logic [31:0] mpc;
        logic        bt;
        logic [31:0] bpc;
        logic        rdy;
        logic        rsp;
        logic        e_rv;
        logic        e_drop;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        trap_take;
    logic [31:0] trap_pc;
    logic        mret_take;
    logic [31:0] mret_pc;
    logic        branch_take;
    logic [31:0] branch_pc;
    logic        misalign;
    logic [31:0] pc_out;

    int total = 0;
    int bad   = 0;

    vec_t vecs [NV];

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN            (32),
        .RESET_VECTOR    (32'h0),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .trap_take   (trap_take),
        .trap_pc     (trap_pc),
        .mret_take   (mret_take),
        .mret_pc     (mret_pc),
        .branch_take (branch_take),
        .branch_pc   (branch_pc),
        .bus         (bus),
        .misalign    (misalign),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic tt, input logic [31:0] tpc,
                                input logic mt, input logic [31:0] mpc,
                                input logic bt, input logic [31:0] bpc,
                                input logic rdy, input logic rsp,
                                input logic e_rv, input logic e_drop,
                                input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v.stall = st;  v.tt = tt;   v.tpc = tpc; v.mt = mt; v.mpc = mpc;
        v.bt = bt;     v.bpc = bpc; v.rdy = rdy; v.rsp = rsp;
        v.e_rv = e_rv; v.e_drop = e_drop; v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic idle_inputs();
        stall = 0; trap_take = 0; trap_pc = '0; mret_take = 0; mret_pc = '0;
        branch_take = 0; branch_pc = '0; bus.req_ready = 0; bus.resp_valid = 0;
    endtask

    initial begin
        int n;
        // Entry state: pc=0x8, two requests outstanding, nothing stale.
        //             st tt tpc        mt mpc       bt bpc           rdy rsp  rv drop pc            mis
        vecs[0]  = mk(0, 0, 0,         0, 0,        0, 0,            1, 1,   0, 0, 32'h8,        0);
        vecs[1]  = mk(0, 0, 0,         0, 0,        0, 0,            1, 1,   1, 0, 32'hC,        0);
        vecs[2]  = mk(0, 0, 0,         0, 0,        0, 0,            1, 1,   1, 0, 32'h10,       0);
        vecs[3]  = mk(0, 0, 0,         0, 0,        0, 0,            1, 1,   1, 0, 32'h14,       0);
        vecs[4]  = mk(0, 0, 0,         0, 0,        0, 0,            0, 1,   1, 0, 32'h14,       0);
        vecs[5]  = mk(1, 0, 0,         0, 0,        1, 32'h100,      1, 0,   0, 0, 32'h100,      0);
        vecs[6]  = mk(1, 0, 0,         0, 0,        0, 0,            1, 0,   0, 0, 32'h100,      0);
        vecs[7]  = mk(0, 0, 0,         0, 0,        0, 0,            1, 0,   1, 0, 32'h104,      0);
        vecs[8]  = mk(0, 0, 0,         0, 0,        0, 0,            1, 0,   1, 0, 32'h108,      0);
        vecs[9]  = mk(0, 0, 0,         0, 0,        1, 32'h200,      1, 0,   0, 0, 32'h200,      0);
        vecs[10] = mk(0, 0, 0,         0, 0,        0, 0,            1, 1,   0, 1, 32'h200,      0);
        vecs[11] = mk(0, 0, 0,         0, 0,        0, 0,            1, 1,   1, 1, 32'h204,      0);
        vecs[12] = mk(0, 0, 0,         0, 0,        0, 0,            0, 1,   1, 0, 32'h204,      0);
        vecs[13] = mk(0, 1, 32'h80,    1, 32'h40,   1, 32'h20,       0, 0,   1, 0, 32'h80,       0);
        vecs[14] = mk(0, 0, 0,         1, 32'h42,   0, 0,            0, 0,   1, 0, 32'h40,       1);
        vecs[15] = mk(0, 0, 0,         0, 0,        0, 0,            0, 0,   1, 0, 32'h40,       0);
        vecs[16] = mk(0, 0, 0,         0, 0,        1, 32'h300,      1, 0,   1, 0, 32'h300,      0);
        vecs[17] = mk(0, 0, 0,         0, 0,        0, 0,            0, 1,   1, 1, 32'h300,      0);
        vecs[18] = mk(0, 1, 32'h1003,  0, 0,        0, 0,            0, 0,   1, 0, 32'h1000,     1);
        vecs[19] = mk(0, 0, 0,         0, 0,        1, 32'hFFFFFFFC, 0, 0,   1, 0, 32'hFFFFFFFC, 0);
        vecs[20] = mk(0, 0, 0,         0, 0,        0, 0,            1, 0,   1, 0, 32'h0,        0);
        vecs[21] = mk(0, 0, 0,         0, 0,        0, 0,            1, 0,   1, 0, 32'h4,        0);
        vecs[22] = mk(0, 0, 0,         0, 0,        0, 0,            1, 0,   0, 0, 32'h4,        0);
        vecs[23] = mk(0, 0, 0,         0, 0,        1, 32'h500,      0, 0,   0, 0, 32'h500,      0);

        // Reset, then the first two fetches fill the outstanding window.
        rst = 1;
        idle_inputs();
        bus.req_ready = 1;
        repeat (3) tick();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_rv", 32'(bus.req_valid), 32'h0);
        chk("rst_mis", 32'(misalign), 32'h0);
        chk("rst_drop", 32'(bus.resp_drop), 32'h0);
        rst = 0;
        #1;
        chk("rv_held_after_rst", 32'(bus.req_valid), 32'h0);
        tick();
        chk("rv_rise", 32'(bus.req_valid), 32'h1);
        chk("first_pc", 32'(bus.req_pc), 32'h0);
        tick();
        chk("second_pc", pc_out, 32'h4);
        chk("second_rv", 32'(bus.req_valid), 32'h1);
        tick();
        chk("window_pc", pc_out, 32'h8);
        chk("window_full_rv", 32'(bus.req_valid), 32'h0);

        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall;
            trap_take = vecs[i].tt;   trap_pc = vecs[i].tpc;
            mret_take = vecs[i].mt;   mret_pc = vecs[i].mpc;
            branch_take = vecs[i].bt; branch_pc = vecs[i].bpc;
            bus.req_ready = vecs[i].rdy;
            bus.resp_valid = vecs[i].rsp;
            #1;
            chk($sformatf("v%0d_rv", i), 32'(bus.req_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_drop", i), 32'(bus.resp_drop), 32'(vecs[i].e_drop));
            tick();
            chk($sformatf("v%0d_pc", i), pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d_req_pc", i), bus.req_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_mis", i), 32'(misalign), 32'(vecs[i].e_mis));
        end

        // Mid-stream reset with two outstanding and two stale: everything must clear.
        idle_inputs();
        bus.req_ready = 1;
        rst = 1;
        tick();
        tick();
        chk("mid_rst_pc", pc_out, 32'h0);
        chk("mid_rst_rv", 32'(bus.req_valid), 32'h0);
        chk("mid_rst_mis", 32'(misalign), 32'h0);
        rst = 0;
        n = 0;
        while (!bus.req_valid && n < 5) begin
            tick();
            n++;
        end
        chk("mid_rst_rv_rise", 32'(bus.req_valid), 32'h1);
        chk("mid_rst_rv_delay", 32'(n), 32'h1);
        chk("mid_rst_pc0", pc_out, 32'h0);
        tick();
        chk("post_rst_pc", pc_out, 32'h4);
        bus.req_ready = 0;
        bus.resp_valid = 1;
        #1;
        chk("post_rst_rv", 32'(bus.req_valid), 32'h1);
        chk("post_rst_drop", 32'(bus.resp_drop), 32'h0);
        tick();
        bus.resp_valid = 0;
        chk("post_rst_hold", pc_out, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
